mc_controller: RTL

Multi-cycle control unit for the MIPS datapath. It decodes the instruction held in the instruction register and walks a FETCH/DECODE/EXEC/MEM/WB state machine. In each state it drives the write enables, IFU mode, ALU operation and datapath mux selects, so one instruction completes every 2–5 cycles. It sits beside the shared datapath (IFU, GRF, EXT, ALU, DM) and replaces the single-cycle controller. It supports the same instruction set: addu, subu, ori, lui, lw, sw, beq, jal, jr, nop.

---
 rtl/mc_controller_pkg.sv | 64 ++++++
 rtl/mc_instr_decoder.sv | 33 +++
 rtl/mc_controller.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states,
// instruction classes, and the datapath control encodings (IFU, EXT, ALU, MUX).
package mc_controller_pkg;

    typedef enum logic [2:0] {
        MC_FETCH  = 3'd0,
        MC_DECODE = 3'd1,
        MC_EXEC   = 3'd2,
        MC_MEM    = 3'd3,
        MC_WB     = 3'd4
    } mc_state_t;

    typedef enum logic [3:0] {
        INSTR_NOP  = 4'd0,
        INSTR_ADDU = 4'd1,
        INSTR_SUBU = 4'd2,
        INSTR_ORI  = 4'd3,
        INSTR_LUI  = 4'd4,
        INSTR_LW   = 4'd5,
        INSTR_SW   = 4'd6,
        INSTR_BEQ  = 4'd7,
        INSTR_JAL  = 4'd8,
        INSTR_JR   = 4'd9
    } instr_class_t;

    // Opcode / funct fields
    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_JR   = 6'h08;

    // Next-PC source
    localparam logic [1:0] IFU_NORMAL = 2'd0;
    localparam logic [1:0] IFU_BRANCH = 2'd1;
    localparam logic [1:0] IFU_JUMP   = 2'd2;
    localparam logic [1:0] IFU_JREG   = 2'd3;

    // Immediate extension
    localparam logic [1:0] EXT_UNSIGNED = 2'd0;
    localparam logic [1:0] EXT_SIGNED   = 2'd1;
    localparam logic [1:0] EXT_SHIFT    = 2'd2;

    // ALU operation
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;

    // Datapath mux selects
    localparam logic [1:0] MUX_ALUOP2_REGSEL   = 2'd0;
    localparam logic [1:0] MUX_ALUOP2_EXTSEL   = 2'd1;
    localparam logic [1:0] MUX_REGWADDR_RDSEL  = 2'd0;
    localparam logic [1:0] MUX_REGWADDR_RTSEL  = 2'd1;
    localparam logic [1:0] MUX_REGWADDR_LINK   = 2'd2;
    localparam logic [1:0] MUX_REGWDATA_ALUSEL = 2'd0;
    localparam logic [1:0] MUX_REGWDATA_MEMSEL = 2'd1;
    localparam logic [1:0] MUX_REGWDATA_LINK   = 2'd2;

endpackage

// File: rtl/mc_instr_decoder.sv
// Combinational instruction classifier: opcode, plus funct for R-type.
// Anything not recognised is reported as a nop.
module mc_instr_decoder
    import mc_controller_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t instr_class
);

    // Map opcode/funct to an instruction class
    always_comb begin
        instr_class = INSTR_NOP;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADDU: instr_class = INSTR_ADDU;
                    FUNCT_SUBU: instr_class = INSTR_SUBU;
                    FUNCT_JR:   instr_class = INSTR_JR;
                    default:    instr_class = INSTR_NOP;
                endcase
            end
            OP_ORI:  instr_class = INSTR_ORI;
            OP_LUI:  instr_class = INSTR_LUI;
            OP_LW:   instr_class = INSTR_LW;
            OP_SW:   instr_class = INSTR_SW;
            OP_BEQ:  instr_class = INSTR_BEQ;
            OP_JAL:  instr_class = INSTR_JAL;
            default: instr_class = INSTR_NOP;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB state machine that
// drives the datapath enables, IFU mode, ALU operation and mux selects.
// The class decoded in DECODE is latched so later states ignore live Instr.
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        ALU_Zero,
    output logic        PC_WEnable,
    output logic        IR_WEnable,
    output logic [1:0]  IFUCG_Mode,
    output logic        GRF_WEnable,
    output logic        DM_WEnable,
    output logic [1:0]  EXT_Mode,
    output logic [3:0]  ALU_Operation,
    output logic [1:0]  MUX_ALUOp2_Sel,
    output logic [1:0]  MUX_RegWAddr_Sel,
    output logic [1:0]  MUX_RegWData_Sel,
    output logic [2:0]  State,
    output logic        Instr_Done
);

    mc_state_t    state, state_next;
    instr_class_t dec_class, cls_q;

    // Register / shamt fields do not affect control
    logic instr_unused;
    assign instr_unused = ^Instr[25:6];

    mc_instr_decoder u_decoder (
        .opcode      (Instr[31:26]),
        .funct       (Instr[5:0]),
        .instr_class (dec_class)
    );

    // State register and class latched at the end of DECODE
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MC_FETCH;
            cls_q <= INSTR_NOP;
        end else begin
            state <= state_next;
            if (state == MC_DECODE) begin
                cls_q <= dec_class;
            end
        end
    end

    // Next-state and per-state outputs; reset forces every output to zero
    always_comb begin
        state_next       = state;
        PC_WEnable       = 1'b0;
        IR_WEnable       = 1'b0;
        IFUCG_Mode       = IFU_NORMAL;
        GRF_WEnable      = 1'b0;
        DM_WEnable       = 1'b0;
        EXT_Mode         = EXT_UNSIGNED;
        ALU_Operation    = ALU_ADD;
        MUX_ALUOp2_Sel   = MUX_ALUOP2_REGSEL;
        MUX_RegWAddr_Sel = MUX_REGWADDR_RDSEL;
        MUX_RegWData_Sel = MUX_REGWDATA_ALUSEL;
        Instr_Done       = 1'b0;

        // Operand controls stay put from EXEC through WB so the ALU result
        // (and the memory address for lw/sw) is stable until it is consumed.
        if (state == MC_EXEC || state == MC_MEM || state == MC_WB) begin
            case (cls_q)
                INSTR_SUBU: ALU_Operation = ALU_SUB;
                INSTR_BEQ:  ALU_Operation = ALU_SUB;
                INSTR_ORI: begin
                    ALU_Operation  = ALU_OR;
                    EXT_Mode       = EXT_UNSIGNED;
                    MUX_ALUOp2_Sel = MUX_ALUOP2_EXTSEL;
                end
                INSTR_LUI: begin
                    ALU_Operation  = ALU_OR;
                    EXT_Mode       = EXT_SHIFT;
                    MUX_ALUOp2_Sel = MUX_ALUOP2_EXTSEL;
                end
                INSTR_LW, INSTR_SW: begin
                    ALU_Operation  = ALU_ADD;
                    EXT_Mode       = EXT_SIGNED;
                    MUX_ALUOp2_Sel = MUX_ALUOP2_EXTSEL;
                end
                default: ALU_Operation = ALU_ADD;
            endcase
        end

        case (state)
            MC_FETCH: begin
                IR_WEnable = 1'b1;
                PC_WEnable = 1'b1;
                IFUCG_Mode = IFU_NORMAL;
                state_next = MC_DECODE;
            end
            MC_DECODE: begin
                if (dec_class == INSTR_NOP) begin
                    Instr_Done = 1'b1;
                    state_next = MC_FETCH;
                end else begin
                    state_next = MC_EXEC;
                end
            end
            MC_EXEC: begin
                case (cls_q)
                    INSTR_ADDU, INSTR_SUBU, INSTR_ORI, INSTR_LUI: state_next = MC_WB;
                    INSTR_LW, INSTR_SW: state_next = MC_MEM;
                    INSTR_BEQ: begin
                        IFUCG_Mode = IFU_BRANCH;
                        PC_WEnable = ALU_Zero;
                        Instr_Done = 1'b1;
                        state_next = MC_FETCH;
                    end
                    INSTR_JAL: begin
                        IFUCG_Mode       = IFU_JUMP;
                        PC_WEnable       = 1'b1;
                        GRF_WEnable      = 1'b1;
                        MUX_RegWAddr_Sel = MUX_REGWADDR_LINK;
                        MUX_RegWData_Sel = MUX_REGWDATA_LINK;
                        Instr_Done       = 1'b1;
                        state_next       = MC_FETCH;
                    end
                    INSTR_JR: begin
                        IFUCG_Mode = IFU_JREG;
                        PC_WEnable = 1'b1;
                        Instr_Done = 1'b1;
                        state_next = MC_FETCH;
                    end
                    default: begin
                        Instr_Done = 1'b1;
                        state_next = MC_FETCH;
                    end
                endcase
            end
            MC_MEM: begin
                if (cls_q == INSTR_SW) begin
                    DM_WEnable = 1'b1;
                    Instr_Done = 1'b1;
                    state_next = MC_FETCH;
                end else begin
                    state_next = MC_WB;
                end
            end
            MC_WB: begin
                GRF_WEnable = 1'b1;
                Instr_Done  = 1'b1;
                state_next  = MC_FETCH;
                if (cls_q == INSTR_ADDU || cls_q == INSTR_SUBU) begin
                    MUX_RegWAddr_Sel = MUX_REGWADDR_RDSEL;
                end else begin
                    MUX_RegWAddr_Sel = MUX_REGWADDR_RTSEL;
                end
                if (cls_q == INSTR_LW) begin
                    MUX_RegWData_Sel = MUX_REGWDATA_MEMSEL;
                end else begin
                    MUX_RegWData_Sel = MUX_REGWDATA_ALUSEL;
                end
            end
            default: state_next = MC_FETCH;
        endcase

        if (reset) begin
            state_next       = MC_FETCH;
            PC_WEnable       = 1'b0;
            IR_WEnable       = 1'b0;
            IFUCG_Mode       = IFU_NORMAL;
            GRF_WEnable      = 1'b0;
            DM_WEnable       = 1'b0;
            EXT_Mode         = EXT_UNSIGNED;
            ALU_Operation    = ALU_ADD;
            MUX_ALUOp2_Sel   = MUX_ALUOP2_REGSEL;
            MUX_RegWAddr_Sel = MUX_REGWADDR_RDSEL;
            MUX_RegWData_Sel = MUX_REGWDATA_ALUSEL;
            Instr_Done       = 1'b0;
        end
    end

    assign State = reset ? 3'd0 : state;

endmodule
